// File: rtl/jtdd_sdram_arb.sv
// Round-robin arbiter sharing one SDRAM read port between SLOTS ROM fetchers.
// One 32-bit read is in flight at a time. The slot that requested it gets a
// one-cycle slot_ok strobe when dout holds its word. Refresh windows are
// offered only while the bus is idle.
module jtdd_sdram_arb #(
  parameter int unsigned SLOTS   = 4,
  parameter int unsigned AW      = 22,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                downloading,
  input  logic                vblank,
  input  logic [SLOTS-1:0]    req,
  input  logic [SLOTS*AW-1:0] addr,
  output logic [SLOTS-1:0]    gnt,
  output logic [SLOTS-1:0]    slot_ok,
  output logic [31:0]         dout,
  output logic                sdram_req,
  output logic [AW-1:0]       sdram_addr,
  input  logic                sdram_ack,
  input  logic                data_rdy,
  input  logic [31:0]         data_read,
  output logic                refresh_en,
  output logic                timeout_err
);

  localparam int unsigned IW = (SLOTS > 1) ? $clog2(SLOTS) : 1;
  localparam int unsigned TW = 8;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t          state, state_nxt;
  logic [IW-1:0]   rr, rr_nxt;
  logic [IW-1:0]   gidx, gidx_nxt;
  logic [TW-1:0]   cnt, cnt_nxt;
  logic [SLOTS-1:0] gnt_nxt, slot_ok_nxt;
  logic [31:0]     dout_nxt;
  logic            sdram_req_nxt, refresh_nxt, terr_nxt;
  logic [AW-1:0]   sdram_addr_nxt;

  logic            pick_vld_c;
  logic [IW-1:0]   pick_idx_c;
  logic [IW-1:0]   cand_c;
  logic [AW-1:0]   slot_addr [SLOTS];

  // Unpack the flat address bus into one word per slot
  for (genvar i = 0; i < SLOTS; i++) begin : g_addr
    assign slot_addr[i] = addr[i*AW +: AW];
  end

  // First pending request at or after the round-robin pointer, with wrap
  always_comb begin
    pick_vld_c = 1'b0;
    pick_idx_c = '0;
    cand_c     = '0;
    for (int unsigned k = 0; k < SLOTS; k++) begin
      cand_c = IW'((32'(rr) + k) % SLOTS);
      if (!pick_vld_c && req[cand_c]) begin
        pick_vld_c = 1'b1;
        pick_idx_c = cand_c;
      end
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_nxt      = state;
    rr_nxt         = rr;
    gidx_nxt       = gidx;
    cnt_nxt        = cnt;
    gnt_nxt        = gnt;
    slot_ok_nxt    = '0;
    dout_nxt       = dout;
    sdram_req_nxt  = sdram_req;
    sdram_addr_nxt = sdram_addr;
    refresh_nxt    = 1'b0;
    terr_nxt       = timeout_err;

    if (downloading) begin
      // Abort whatever is in flight; the rr pointer survives
      state_nxt     = IDLE;
      gnt_nxt       = '0;
      sdram_req_nxt = 1'b0;
      cnt_nxt       = '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_vld_c) begin
            gidx_nxt       = pick_idx_c;
            gnt_nxt        = SLOTS'(1) << pick_idx_c;
            sdram_addr_nxt = slot_addr[pick_idx_c];
            sdram_req_nxt  = 1'b1;
            state_nxt      = ISSUE;
          end else begin
            refresh_nxt = vblank;
          end
        end
        ISSUE: begin
          if (sdram_ack) begin
            sdram_req_nxt = 1'b0;
            cnt_nxt       = '0;
            state_nxt     = WAIT;
          end
        end
        WAIT: begin
          if (data_rdy) begin
            dout_nxt  = data_read;
            state_nxt = DONE;
          end else if (cnt == TW'(TIMEOUT - 1)) begin
            terr_nxt  = 1'b1;
            gnt_nxt   = '0;
            state_nxt = IDLE;
          end else begin
            cnt_nxt = cnt + TW'(1);
          end
        end
        DONE: begin
          // A slot that withdrew its request gets no strobe
          slot_ok_nxt = gnt & req;
          rr_nxt      = (gidx == IW'(SLOTS - 1)) ? '0 : gidx + IW'(1);
          gnt_nxt     = '0;
          state_nxt   = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      rr          <= '0;
      gidx        <= '0;
      cnt         <= '0;
      gnt         <= '0;
      slot_ok     <= '0;
      dout        <= '0;
      sdram_req   <= 1'b0;
      sdram_addr  <= '0;
      refresh_en  <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_nxt;
      rr          <= rr_nxt;
      gidx        <= gidx_nxt;
      cnt         <= cnt_nxt;
      gnt         <= gnt_nxt;
      slot_ok     <= slot_ok_nxt;
      dout        <= dout_nxt;
      sdram_req   <= sdram_req_nxt;
      sdram_addr  <= sdram_addr_nxt;
      refresh_en  <= refresh_nxt;
      timeout_err <= terr_nxt;
    end
  end

endmodule
